// File: rtl/video_timing_gen.sv
// Raster timing generator: lookahead/current pixel coordinates, syncs, visible flags and strobes.
// Optional frame counter output enabled by defining VIDEO_TIMING_FRAME_CNT_EN.
module video_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned SYNC_POL  = 0
) (
  input  logic       pixel_clk,
  input  logic       reset_n,
  input  logic       enable,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic [9:0] next_pixel_x,
  output logic [9:0] next_pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       next_video_on,
  output logic       frame_start,
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  output logic [15:0] frame_count,
`endif
  output logic       line_end
);

  localparam int unsigned CW       = 10;
  localparam int unsigned XW       = 11;
  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_VISIBLE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam logic        SYNC_ON  = 1'(SYNC_POL);

  if (H_TOTAL > 1024) begin : g_h_total_chk
    $error("video_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_v_total_chk
    $error("video_timing_gen: V_TOTAL exceeds 1024");
  end

  logic [CW-1:0] nx_q, nx_d, ny_q, ny_d;
  logic [CW-1:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          video_on_q, video_on_d, next_video_on_q, next_video_on_d;
  logic          frame_start_q, frame_start_d, line_end_q, line_end_d;
  logic          h_wrap_c, v_wrap_c, at_origin_c;
  logic [CW-1:0] nx_succ_c, ny_succ_c;
  logic [XW-1:0] nx_ext_c, ny_ext_c, nx_succ_ext_c, ny_succ_ext_c;

  // Successor of the lookahead pair, shared by the counter update and next_video_on
  always_comb begin
    h_wrap_c    = (nx_q == CW'(H_TOTAL - 1));
    v_wrap_c    = (ny_q == CW'(V_TOTAL - 1));
    at_origin_c = (nx_q == '0) && (ny_q == '0);
    nx_succ_c   = h_wrap_c ? '0 : nx_q + CW'(1);
    ny_succ_c   = ny_q;
    if (h_wrap_c) begin
      ny_succ_c = v_wrap_c ? '0 : ny_q + CW'(1);
    end
    nx_ext_c      = {1'b0, nx_q};
    ny_ext_c      = {1'b0, ny_q};
    nx_succ_ext_c = {1'b0, nx_succ_c};
    ny_succ_ext_c = {1'b0, ny_succ_c};
  end

  // Next-state decode; everything holds while enable is low
  always_comb begin
    nx_d            = nx_q;
    ny_d            = ny_q;
    pixel_x_d       = pixel_x_q;
    pixel_y_d       = pixel_y_q;
    hsync_d         = hsync_q;
    vsync_d         = vsync_q;
    video_on_d      = video_on_q;
    next_video_on_d = next_video_on_q;
    frame_start_d   = frame_start_q;
    line_end_d      = line_end_q;
    if (enable) begin
      nx_d            = nx_succ_c;
      ny_d            = ny_succ_c;
      pixel_x_d       = nx_q;
      pixel_y_d       = ny_q;
      hsync_d         = ((nx_ext_c >= XW'(HS_START)) && (nx_ext_c < XW'(HS_END))) ? SYNC_ON : ~SYNC_ON;
      vsync_d         = ((ny_ext_c >= XW'(VS_START)) && (ny_ext_c < XW'(VS_END))) ? SYNC_ON : ~SYNC_ON;
      video_on_d      = (nx_ext_c < XW'(H_VISIBLE)) && (ny_ext_c < XW'(V_VISIBLE));
      next_video_on_d = (nx_succ_ext_c < XW'(H_VISIBLE)) && (ny_succ_ext_c < XW'(V_VISIBLE));
      frame_start_d   = at_origin_c;
      line_end_d      = (nx_ext_c == XW'(H_VISIBLE - 1)) && (ny_ext_c < XW'(V_VISIBLE));
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      nx_q            <= '0;
      ny_q            <= '0;
      pixel_x_q       <= CW'(H_TOTAL - 1);
      pixel_y_q       <= CW'(V_TOTAL - 1);
      hsync_q         <= ~SYNC_ON;
      vsync_q         <= ~SYNC_ON;
      video_on_q      <= 1'b0;
      next_video_on_q <= 1'b1;
      frame_start_q   <= 1'b0;
      line_end_q      <= 1'b0;
    end else begin
      nx_q            <= nx_d;
      ny_q            <= ny_d;
      pixel_x_q       <= pixel_x_d;
      pixel_y_q       <= pixel_y_d;
      hsync_q         <= hsync_d;
      vsync_q         <= vsync_d;
      video_on_q      <= video_on_d;
      next_video_on_q <= next_video_on_d;
      frame_start_q   <= frame_start_d;
      line_end_q      <= line_end_d;
    end
  end

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;
  logic        seen_frame_q, seen_frame_d;

  // The first frame after reset is frame 0, so only later frame starts count
  always_comb begin
    frame_count_d = frame_count_q;
    seen_frame_d  = seen_frame_q;
    if (enable && at_origin_c) begin
      seen_frame_d = 1'b1;
      if (seen_frame_q) begin
        frame_count_d = frame_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_q <= '0;
      seen_frame_q  <= 1'b0;
    end else begin
      frame_count_q <= frame_count_d;
      seen_frame_q  <= seen_frame_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

  assign pixel_x       = pixel_x_q;
  assign pixel_y       = pixel_y_q;
  assign next_pixel_x  = nx_q;
  assign next_pixel_y  = ny_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign video_on      = video_on_q;
  assign next_video_on = next_video_on_q;
  assign frame_start   = frame_start_q;
  assign line_end      = line_end_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized-enable bench for video_timing_gen against a pixel-count reference model.
module tb_video_timing_gen;

  localparam int unsigned HV = 16, HF = 2, HS = 4, HB = 3;
  localparam int unsigned VV = 10, VF = 2, VS = 2, VB = 3;
  localparam int unsigned POL = 1;
  localparam int unsigned HT = HV + HF + HS + HB;
  localparam int unsigned VT = VV + VF + VS + VB;
  localparam int unsigned FR = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [9:0] pixel_x, pixel_y, next_pixel_x, next_pixel_y;
  logic       hsync, vsync, video_on, next_video_on, frame_start, line_end;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [15:0] frame_count;
`endif

  int compared   = 0;
  int mismatched = 0;
  int t          = 0;  // advancing clocks since last reset

  video_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL)
  ) dut (
    .pixel_clk    (clk),
    .reset_n      (rst_n),
    .enable       (en),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .next_pixel_x (next_pixel_x),
    .next_pixel_y (next_pixel_y),
    .hsync        (hsync),
    .vsync        (vsync),
    .video_on     (video_on),
    .next_video_on(next_video_on),
    .frame_start  (frame_start),
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    .frame_count  (frame_count),
`endif
    .line_end     (line_end)
  );

  always #20 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Expected outputs follow from how many pixels have elapsed since reset
  task automatic check_all();
    int x, y, nxx, nyy, idx, n, fc;
    logic ehs, evs, evon, envon, efs, ele;
    if (t == 0) begin
      x = HT - 1; y = VT - 1; nxx = 0; nyy = 0;
      evon = 1'b0; efs = 1'b0; ele = 1'b0; envon = 1'b1; fc = 0;
      ehs = ~1'(POL); evs = ~1'(POL);
    end else begin
      idx = (t - 1) % FR;
      n   = t % FR;
      x = idx % HT; y = idx / HT;
      nxx = n % HT; nyy = n / HT;
      evon  = (x < HV) && (y < VV);
      envon = (nxx < HV) && (nyy < VV);
      efs   = (idx == 0);
      ele   = (x == HV - 1) && (y < VV);
      ehs   = (x >= HV + HF && x < HV + HF + HS) ? 1'(POL) : ~1'(POL);
      evs   = (y >= VV + VF && y < VV + VF + VS) ? 1'(POL) : ~1'(POL);
      fc    = ((t - 1) / FR) % 65536;
    end
    cmp("pixel_x", 32'(pixel_x), 32'(x));
    cmp("pixel_y", 32'(pixel_y), 32'(y));
    cmp("next_pixel_x", 32'(next_pixel_x), 32'(nxx));
    cmp("next_pixel_y", 32'(next_pixel_y), 32'(nyy));
    cmp("hsync", 32'(hsync), 32'(ehs));
    cmp("vsync", 32'(vsync), 32'(evs));
    cmp("video_on", 32'(video_on), 32'(evon));
    cmp("next_video_on", 32'(next_video_on), 32'(envon));
    cmp("frame_start", 32'(frame_start), 32'(efs));
    cmp("line_end", 32'(line_end), 32'(ele));
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    cmp("frame_count", 32'(frame_count), 32'(fc));
`endif
  endtask

  task automatic step(input logic e);
    en = e;
    @(posedge clk);
    if (e && rst_n) t++;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    t = 0;
    check_all();

    // Release with enable high: first pixel is the frame origin
    rst_n = 1'b1;
    step(1'b1);
    step(1'b1);

    // Several frames under random enable gaps
    for (int i = 0; i < 2500; i++) begin
      step(($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0);
    end

    // Freeze for 5 clocks mid-line
    for (int i = 0; i < 5; i++) step(1'b0);
    step(1'b1);

    // Asynchronous reset between clock edges
    @(posedge clk);
    #5 rst_n = 1'b0;
    #1 t = 0;
    check_all();
    step(1'b1);
    rst_n = 1'b1;
    step(1'b1);
    step(1'b1);

    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Free-running raster timing generator, directly upstream of the video pixel generator. Runs on the 25 MHz pixel clock.
- Produces the current and one-cycle-lookahead pixel coordinates, HSYNC/VSYNC, and the visible-area flags.
- Also produces frame-start and line-end strobes. The pixel generator uses these to build RGB and the AXI4-Stream SOF (tuser) and EOL (tlast) sideband.
- Defaults give 640x480 at 60 Hz: 800x525 total.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, HSYNC pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VSYNC pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of HSYNC and VSYNC (0 = active-low)

Ports:
- pixel_clk  in  1  pixel clock, 25 MHz
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  when high, the raster advances one pixel per clock; when low, all state holds
- pixel_x  out  10  current column, 0..H_TOTAL-1
- pixel_y  out  10  current line, 0..V_TOTAL-1
- next_pixel_x  out  10  column that pixel_x will take on the next advancing cycle
- next_pixel_y  out  10  line that pixel_y will take on the next advancing cycle
- hsync  out  1  horizontal sync, aligned to pixel_x
- vsync  out  1  vertical sync, aligned to pixel_y
- video_on  out  1  current pixel lies in the visible area
- next_video_on  out  1  next pixel lies in the visible area
- frame_start  out  1  single-cycle pulse while (pixel_x, pixel_y) = (0, 0)
- line_end  out  1  high while pixel_x = H_VISIBLE-1 and pixel_y < V_VISIBLE

Behaviour:
- Derived constants: H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525).
- Elaboration checks: error if H_TOTAL > 1024 or V_TOTAL > 1024.
- Core state is the lookahead counter pair (nx, ny), driven onto next_pixel_x / next_pixel_y.
- On each clock with enable = 1:
  - nx increments by 1. When nx = H_TOTAL-1, nx wraps to 0 and ny increments.
  - When ny = V_TOTAL-1 at the same time as the nx wrap, ny wraps to 0.
- pixel_x / pixel_y register (nx, ny) on each clock with enable = 1. Invariant: pixel coordinates equal the previous next_pixel coordinates, i.e. one cycle of latency.
- All remaining outputs are registered and decoded from (nx, ny), so each is aligned to pixel_x / pixel_y:
  - hsync: active when H_VISIBLE+H_FP <= x < H_VISIBLE+H_FP+H_SYNC. Defaults: x = 656..751.
  - vsync: active when V_VISIBLE+V_FP <= y < V_VISIBLE+V_FP+V_SYNC. Defaults: y = 490..491.
  - Active level of both syncs is SYNC_POL; inactive is the inverse.
  - video_on = (x < H_VISIBLE) and (y < V_VISIBLE).
- next_video_on is registered and decoded from the successor of (nx, ny), so it is always aligned to next_pixel_x / next_pixel_y.
- enable = 0: every register, including the strobes, holds its value. The strobe holds are deliberate, so a stalled consumer keeps seeing the same pixel.
- Reset (asynchronous assert, synchronous deassert handled outside this block):
  - nx = 0, ny = 0
  - pixel_x = H_TOTAL-1, pixel_y = V_TOTAL-1
  - hsync = vsync = inactive
  - video_on = 0
  - next_video_on = 1
  - frame_start = 0, line_end = 0
- Reset mid-frame returns immediately to the reset state above. The first advancing clock after release yields pixel = (0, 0) and frame_start = 1.
- No other inputs exist; there is no illegal state. Counters never exceed H_TOTAL-1 / V_TOTAL-1.

Optional Feature:
- Macro: VIDEO_TIMING_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_count (16 bits, reset 0).
  - frame_count increments by 1, wrapping at 0xFFFF, on the same clock that frame_start rises, except the first frame after reset. So frame_count = 1 during the second frame.
  - Used for on-screen debug and ILA triggering.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset release with enable = 1 -> first clock gives pixel = (0,0), frame_start = 1, video_on = 1, next_pixel = (1,0). Second clock gives frame_start = 0.
- Run one line -> at pixel_x = 639: line_end = 1 and next_video_on = 0. At pixel_x = 640: video_on = 0. hsync is active exactly for pixel_x 656..751 (96 cycles). pixel_x 799 is followed by (0,1).
- Run a full frame -> frame_start recurs after exactly 420000 clocks. vsync is active for pixel_y 490..491 (1600 clocks). next_pixel at (799,524) = (0,0).
- Toggle enable low for 5 clocks at pixel = (100,10) -> every output is frozen for those 5 clocks. Counting resumes at (101,10).
- Assert reset_n = 0 at pixel (300,200) -> outputs take their reset values asynchronously, before the next clock edge. Release gives the same sequence as the first scenario.
- With VIDEO_TIMING_FRAME_CNT_EN and SYNC_POL = 1 -> frame_count = 0, 1, 2 across three frames. hsync and vsync are high while active.
